// File: rtl/fp_pipe_pkg.sv
// rtl/fp_pipe_pkg.sv - shared constants and payload layout helpers for the FP add pipeline
package fp_pipe_pkg;

  localparam int SP_EXP_W  = 10;
  localparam int SP_FRAC_W = 23;
  localparam int SP_Z_W    = 48;
  localparam int DP_EXP_W  = 13;
  localparam int DP_FRAC_W = 52;
  localparam int DP_Z_W    = 106;

  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RTZ = 2'd1;
  localparam logic [1:0] RM_RDN = 2'd2;
  localparam logic [1:0] RM_RUP = 2'd3;

  // Encodings equal the number of held entries so occ can be driven from the state.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  // Payload layout, MSB to LSB: {rm, sign, exp, is_nan, is_inf, inf_nan_frac, z}
  function automatic int payload_w(input int exp_w, input int frac_w, input int z_w);
    return 2 + 1 + exp_w + 1 + 1 + frac_w + z_w;
  endfunction

  function automatic int frac_lsb(input int z_w);
    return z_w;
  endfunction

  function automatic int inf_lsb(input int frac_w, input int z_w);
    return z_w + frac_w;
  endfunction

  function automatic int nan_lsb(input int frac_w, input int z_w);
    return z_w + frac_w + 1;
  endfunction

  function automatic int exp_lsb(input int frac_w, input int z_w);
    return z_w + frac_w + 2;
  endfunction

  function automatic int sign_lsb(input int exp_w, input int frac_w, input int z_w);
    return z_w + frac_w + 2 + exp_w;
  endfunction

  function automatic int rm_lsb(input int exp_w, input int frac_w, input int z_w);
    return z_w + frac_w + 3 + exp_w;
  endfunction

endpackage

// File: rtl/skid_buf_core.sv
// rtl/skid_buf_core.sv - width-generic 2-entry skid buffer with registered ready and sync flush
module skid_buf_core
  import fp_pipe_pkg::*;
#(
  parameter int W            = 86,
  parameter bit CLR_ON_FLUSH = 1'b0
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occ
);

  logic [1:0]   state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         ready_q;
  logic         in_fire, out_fire;

  assign in_fire   = in_valid & ready_q;
  assign out_fire  = (state_q != ST_EMPTY) & out_ready;
  assign in_ready  = ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occ       = state_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = ST_TWO;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over any transfer; a coincident out_fire was already consumed downstream.
    if (flush) begin
      state_d = ST_EMPTY;
      if (CLR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end else begin
        main_d = main_q;
        skid_d = skid_q;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != ST_TWO);
    end
  end

endmodule

// File: rtl/fp_pipe_skid_stage.sv
// rtl/fp_pipe_skid_stage.sv - elastic add-to-normalize stage register for the FP adder
module fp_pipe_skid_stage
  import fp_pipe_pkg::*;
#(
  parameter int EXP_W        = SP_EXP_W,
  parameter int FRAC_W       = SP_FRAC_W,
  parameter int Z_W          = SP_Z_W,
  parameter bit CLR_ON_FLUSH = 1'b0
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_rm,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_is_nan,
  input  logic              in_is_inf,
  input  logic [FRAC_W-1:0] in_inf_nan_frac,
  input  logic [Z_W-1:0]    in_z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_rm,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_is_nan,
  output logic              out_is_inf,
  output logic [FRAC_W-1:0] out_inf_nan_frac,
  output logic [Z_W-1:0]    out_z,
  output logic [1:0]        occ
);

  localparam int P      = payload_w(EXP_W, FRAC_W, Z_W);
  localparam int L_FRAC = frac_lsb(Z_W);
  localparam int L_INF  = inf_lsb(FRAC_W, Z_W);
  localparam int L_NAN  = nan_lsb(FRAC_W, Z_W);
  localparam int L_EXP  = exp_lsb(FRAC_W, Z_W);
  localparam int L_SIGN = sign_lsb(EXP_W, FRAC_W, Z_W);
  localparam int L_RM   = rm_lsb(EXP_W, FRAC_W, Z_W);

  logic [P-1:0] in_data, out_data;

  assign in_data = {in_rm, in_sign, in_exp, in_is_nan, in_is_inf, in_inf_nan_frac, in_z};

  skid_buf_core #(
    .W            (P),
    .CLR_ON_FLUSH (CLR_ON_FLUSH)
  ) u_core (
    .clk       (clk),
    .clrn      (clrn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occ       (occ)
  );

  assign out_z            = out_data[0 +: Z_W];
  assign out_inf_nan_frac = out_data[L_FRAC +: FRAC_W];
  assign out_is_inf       = out_data[L_INF];
  assign out_is_nan       = out_data[L_NAN];
  assign out_exp          = out_data[L_EXP +: EXP_W];
  assign out_sign         = out_data[L_SIGN];
  assign out_rm           = out_data[L_RM +: 2];

endmodule

// File: tb/tb_fp_pipe_skid_stage.sv
// tb/tb_fp_pipe_skid_stage.sv - scoreboard bench for the FP skid stage (SP and DP instances)
module tb_fp_pipe_skid_stage;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  // Single-precision instance, payload held on flush
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_rm, out_rm, occ;
  logic        in_sign, out_sign, in_is_nan, out_is_nan, in_is_inf, out_is_inf;
  logic [9:0]  in_exp, out_exp;
  logic [22:0] in_frac, out_frac;
  logic [47:0] in_z, out_z;

  fp_pipe_skid_stage #(.EXP_W(10), .FRAC_W(23), .Z_W(48), .CLR_ON_FLUSH(1'b0)) dut (
    .clk(clk), .clrn(clrn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rm(in_rm), .in_sign(in_sign), .in_exp(in_exp), .in_is_nan(in_is_nan),
    .in_is_inf(in_is_inf), .in_inf_nan_frac(in_frac), .in_z(in_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rm(out_rm), .out_sign(out_sign), .out_exp(out_exp), .out_is_nan(out_is_nan),
    .out_is_inf(out_is_inf), .out_inf_nan_frac(out_frac), .out_z(out_z),
    .occ(occ)
  );

  // Double-precision instance, payload zeroed on flush
  logic         d_flush, d_in_valid, d_in_ready, d_out_valid, d_out_ready;
  logic [1:0]   d_in_rm, d_out_rm, d_occ;
  logic         d_in_sign, d_out_sign, d_in_is_nan, d_out_is_nan, d_in_is_inf, d_out_is_inf;
  logic [12:0]  d_in_exp, d_out_exp;
  logic [51:0]  d_in_frac, d_out_frac;
  logic [105:0] d_in_z, d_out_z;

  fp_pipe_skid_stage #(.EXP_W(13), .FRAC_W(52), .Z_W(106), .CLR_ON_FLUSH(1'b1)) dut_dp (
    .clk(clk), .clrn(clrn), .flush(d_flush),
    .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_rm(d_in_rm), .in_sign(d_in_sign), .in_exp(d_in_exp), .in_is_nan(d_in_is_nan),
    .in_is_inf(d_in_is_inf), .in_inf_nan_frac(d_in_frac), .in_z(d_in_z),
    .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_rm(d_out_rm), .out_sign(d_out_sign), .out_exp(d_out_exp), .out_is_nan(d_out_is_nan),
    .out_is_inf(d_out_is_inf), .out_inf_nan_frac(d_out_frac), .out_z(d_out_z),
    .occ(d_occ)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int pops    = 0;
  logic [85:0] expq[$];

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  function automatic logic [85:0] mk(input logic [1:0] rm, input logic s, input logic [9:0] e,
                                     input logic n, input logic f_inf, input logic [22:0] fr,
                                     input logic [47:0] z);
    return {rm, s, e, n, f_inf, fr, z};
  endfunction

  task automatic drive(input logic [85:0] p);
    {in_rm, in_sign, in_exp, in_is_nan, in_is_inf, in_frac, in_z} = p;
  endtask

  // Offer one entry; the expected output is queued on the cycle it will be accepted.
  task automatic send(input logic [85:0] p, output int waits);
    waits = 0;
    drive(p);
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        expq.push_back(p);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      waits++;
    end
    in_valid = 1'b0;
    check("send_timeout", 192'(waits), 192'(0));
  endtask

  // Monitor: compares every output handshake against the head of the expected queue.
  always @(negedge clk) begin
    if (!clrn) begin
      expq.delete();
    end else begin
      if (out_valid && out_ready) begin
        pops++;
        if (expq.size() == 0) begin
          check("unexpected_out", 192'({out_rm, out_sign, out_exp, out_is_nan, out_is_inf, out_frac, out_z}), 192'(0));
        end else begin
          check("sb_payload", 192'({out_rm, out_sign, out_exp, out_is_nan, out_is_inf, out_frac, out_z}),
                192'(expq.pop_front()));
        end
      end
      if (flush) expq.delete();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, stall;
    logic [85:0] e0, e1, e2;

    clrn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; drive('0);
    d_flush = 1'b0; d_in_valid = 1'b0; d_out_ready = 1'b0;
    d_in_rm = '0; d_in_sign = 1'b0; d_in_exp = '0; d_in_is_nan = 1'b0; d_in_is_inf = 1'b0;
    d_in_frac = '0; d_in_z = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 192'(out_valid), 192'(0));
    check("rst_occ", 192'(occ), 192'(0));
    check("rst_in_ready", 192'(in_ready), 192'(0));
    check("rst_out_z", 192'(out_z), 192'(0));
    clrn = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", 192'(in_ready), 192'(1));
    check("dp_ready_after_rst", 192'(d_in_ready), 192'(1));

    // Single entry, 1-cycle latency
    out_ready = 1'b1;
    send(mk(2'd2, 1'b1, 10'h07F, 1'b0, 1'b0, 23'h0, 48'h800000000001), w);
    check("single_latency", 192'(out_valid), 192'(1));
    check("single_exp", 192'(out_exp), 192'(10'h07F));
    check("single_z", 192'(out_z), 192'(48'h800000000001));
    @(posedge clk);
    #1;
    check("single_drain_occ", 192'(occ), 192'(0));

    // Back-to-back stream of 8
    stall = 0;
    for (int i = 0; i < 8; i++) begin
      send(mk(i[1:0], i[0], 10'(i), 1'b0, 1'b0, 23'(i * 3), 48'(i * 48'h1_0000_0001)), w);
      stall += w;
    end
    check("stream_no_stall", 192'(stall), 192'(0));
    repeat (2) @(posedge clk);
    #1;
    check("stream_pops", 192'(pops), 192'(9));

    // Backpressure: two accepted, third held upstream
    out_ready = 1'b0;
    e0 = mk(2'd0, 1'b0, 10'h100, 1'b0, 1'b0, 23'h1, 48'hA);
    e1 = mk(2'd1, 1'b1, 10'h101, 1'b0, 1'b1, 23'h2, 48'hB);
    e2 = mk(2'd3, 1'b0, 10'h102, 1'b1, 1'b0, 23'h3, 48'hC);
    fork
      begin
        send(e0, w); send(e1, w); send(e2, w);
      end
      begin
        repeat (2) @(posedge clk);
        #2;
        check("bp_occ2", 192'(occ), 192'(2));
        check("bp_not_ready", 192'(in_ready), 192'(0));
        repeat (3) @(posedge clk);
        #2;
        check("bp_hold_occ", 192'(occ), 192'(2));
        check("bp_stable_exp", 192'(out_exp), 192'(10'h100));
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    check("bp_pops", 192'(pops), 192'(12));
    check("bp_drain_occ", 192'(occ), 192'(0));

    // Flush at occ=2 with an entry offered in the same cycle
    out_ready = 1'b0;
    send(mk(2'd0, 1'b0, 10'h200, 1'b0, 1'b0, 23'h0, 48'h1234), w);
    send(mk(2'd0, 1'b0, 10'h201, 1'b0, 1'b0, 23'h0, 48'h5678), w);
    drive(mk(2'd1, 1'b1, 10'h202, 1'b0, 1'b0, 23'h0, 48'h9ABC));
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_out_valid", 192'(out_valid), 192'(0));
    check("flush_occ", 192'(occ), 192'(0));
    check("flush_in_ready", 192'(in_ready), 192'(1));
    check("flush_hold_z", 192'(out_z), 192'(48'h1234));

    // Flush at occ=1 while a transfer is actually accepted
    send(mk(2'd2, 1'b0, 10'h210, 1'b0, 1'b0, 23'h0, 48'h1111), w);
    drive(mk(2'd2, 1'b0, 10'h211, 1'b0, 1'b0, 23'h0, 48'h2222));
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush1_occ", 192'(occ), 192'(0));
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("flush_no_leak", 192'(pops), 192'(12));

    // DP: payload zeroed on flush
    d_in_z = 106'h3_0000_0000_0000_0000_0000_0001; d_in_frac = 52'h12345; d_in_exp = 13'h0AA;
    d_in_valid = 1'b1;
    @(posedge clk);
    #1;
    d_in_valid = 1'b0;
    check("dp_load_occ", 192'(d_occ), 192'(1));
    check("dp_load_z", 192'(d_out_z), 192'(106'h3_0000_0000_0000_0000_0000_0001));
    d_flush = 1'b1;
    @(posedge clk);
    #1;
    d_flush = 1'b0;
    check("dp_flush_z0", 192'(d_out_z), 192'(0));
    check("dp_flush_frac0", 192'(d_out_frac), 192'(0));
    check("dp_flush_occ", 192'(d_occ), 192'(0));

    // DP: NaN entry passes unmodified
    d_out_ready = 1'b1;
    d_in_rm = 2'd1; d_in_sign = 1'b0; d_in_exp = 13'h1FFF; d_in_is_nan = 1'b1; d_in_is_inf = 1'b0;
    d_in_frac = 52'h8000000000000; d_in_z = 106'h2AA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
    d_in_valid = 1'b1;
    @(posedge clk);
    #1;
    d_in_valid = 1'b0;
    check("dp_nan_valid", 192'(d_out_valid), 192'(1));
    check("dp_nan_flag", 192'({d_out_is_nan, d_out_is_inf, d_out_sign, d_out_rm}), 192'(5'b10001));
    check("dp_nan_frac", 192'(d_out_frac), 192'(52'h8000000000000));
    check("dp_nan_exp", 192'(d_out_exp), 192'(13'h1FFF));
    check("dp_nan_z", 192'(d_out_z), 192'(106'h2AA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA));

    // Async reset mid-stream at occ=2
    out_ready = 1'b0;
    send(mk(2'd3, 1'b1, 10'h300, 1'b0, 1'b0, 23'h7, 48'hFFFF), w);
    send(mk(2'd3, 1'b1, 10'h301, 1'b0, 1'b0, 23'h8, 48'hEEEE), w);
    #2;
    clrn = 1'b0;
    #1;
    check("arst_out_valid", 192'(out_valid), 192'(0));
    check("arst_occ", 192'(occ), 192'(0));
    check("arst_out_z", 192'(out_z), 192'(0));
    check("arst_in_ready", 192'(in_ready), 192'(0));
    @(posedge clk);
    #1;
    clrn = 1'b1;
    @(posedge clk);
    #1;
    check("arst_ready_back", 192'(in_ready), 192'(1));
    out_ready = 1'b1;
    send(mk(2'd1, 1'b0, 10'h3AB, 1'b0, 1'b1, 23'h55, 48'h42), w);
    check("arst_latency", 192'(out_valid), 192'(1));
    @(posedge clk);
    #1;
    check("final_pops", 192'(pops), 192'(13));
    check("final_queue_empty", 192'(expq.size()), 192'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
